// File: rtl/f_redirect_ctrl_pkg.sv
// f_redirect_ctrl_pkg: shared types for the frontend redirect controller
package f_redirect_ctrl_pkg;

    typedef struct packed {
        logic        redirect;
        logic [31:0] redir_addr;
    } correct_info_t;

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} redir_state_e;

endpackage

// File: rtl/f_redir_pick.sv
// f_redir_pick: fixed-priority pick of exception > slot 0 > slot 1 redirect
module f_redir_pick
    import f_redirect_ctrl_pkg::*;
(
    input  correct_info_t [1:0] correct_infos_i,
    input  logic                exc_valid_i,
    input  logic [31:0]         exc_addr_i,
    output logic                vld_o,
    output logic [31:0]         addr_o
);

    assign vld_o  = exc_valid_i | correct_infos_i[0].redirect | correct_infos_i[1].redirect;
    assign addr_o = exc_valid_i                ? exc_addr_i :
                    correct_infos_i[0].redirect ? correct_infos_i[0].redir_addr :
                                                  correct_infos_i[1].redir_addr;

endmodule

// File: rtl/f_redirect_ctrl.sv
// f_redirect_ctrl: waits for icache drain then pulses g_flush with the redirect PC.
// Optional statistics counters are enabled by defining F_REDIR_STAT_EN.
module f_redirect_ctrl
    import f_redirect_ctrl_pkg::*;
#(
    parameter int DRAIN_MAX = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  correct_info_t [1:0] correct_infos_i,
    input  logic                exc_valid_i,
    input  logic [31:0]         exc_addr_i,
    input  logic                icache_busy_i,
    output logic                g_flush_o,
    output logic [31:0]         redir_pc_o,
    output logic                fetch_stall_o
`ifdef F_REDIR_STAT_EN
    ,
    output logic [31:0]         stat_flush_cnt_o,
    output logic [31:0]         stat_drain_cyc_o,
    output logic                stat_timeout_o
`endif
);

    localparam int CNT_W = $clog2(DRAIN_MAX + 1);

    redir_state_e     state_q, state_d;
    logic [31:0]      tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_vld;
    logic [31:0]      req_addr;
    logic             wd_hit;

    f_redir_pick u_pick (
        .correct_infos_i (correct_infos_i),
        .exc_valid_i     (exc_valid_i),
        .exc_addr_i      (exc_addr_i),
        .vld_o           (req_vld),
        .addr_o          (req_addr)
    );

    assign wd_hit = (cnt_q == CNT_W'(DRAIN_MAX - 1));

    // next state: DRAIN keeps counting through new requests; IDLE/FLUSH restart on a request
    always_comb begin
        state_d = state_q;
        tgt_d   = req_vld ? req_addr : tgt_q;
        cnt_d   = cnt_q;
        if (state_q == DRAIN) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (!icache_busy_i || wd_hit) ? FLUSH : DRAIN;
        end else if (req_vld) begin
            cnt_d   = '0;
            state_d = icache_busy_i ? DRAIN : FLUSH;
        end else begin
            state_d = IDLE;
        end
    end

    // redirect state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign g_flush_o     = (state_q == FLUSH);
    assign redir_pc_o    = tgt_q;
    assign fetch_stall_o = (state_q != IDLE);

`ifdef F_REDIR_STAT_EN
    // saturating flush/drain counters and sticky watchdog-timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_flush_cnt_o <= '0;
            stat_drain_cyc_o <= '0;
            stat_timeout_o   <= 1'b0;
        end else begin
            if (state_q == FLUSH && stat_flush_cnt_o != '1)
                stat_flush_cnt_o <= stat_flush_cnt_o + 1'b1;
            if (state_q == DRAIN && stat_drain_cyc_o != '1)
                stat_drain_cyc_o <= stat_drain_cyc_o + 1'b1;
            if (state_q == DRAIN && icache_busy_i && wd_hit)
                stat_timeout_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_f_redirect_ctrl.sv
// tb_f_redirect_ctrl: scoreboard bench; expected flushes queued at stimulus, checked by a monitor
module tb_f_redirect_ctrl;
    import f_redirect_ctrl_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    correct_info_t [1:0] ci;
    logic                exc_v;
    logic [31:0]         exc_a;
    logic                busy;
    logic                g_flush;
    logic [31:0]         pc;
    logic                stall;
`ifdef F_REDIR_STAT_EN
    logic [31:0]         s_fl;
    logic [31:0]         s_dr;
    logic                s_to;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int          c;
        logic [31:0] a;
    } exp_t;
    exp_t sb[$];

    f_redirect_ctrl #(.DRAIN_MAX(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .correct_infos_i (ci),
        .exc_valid_i     (exc_v),
        .exc_addr_i      (exc_a),
        .icache_busy_i   (busy),
        .g_flush_o       (g_flush),
        .redir_pc_o      (pc),
        .fetch_stall_o   (stall)
`ifdef F_REDIR_STAT_EN
        ,
        .stat_flush_cnt_o(s_fl),
        .stat_drain_cyc_o(s_dr),
        .stat_timeout_o  (s_to)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor: every flush pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && g_flush) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_flush: got flush at cycle %0d pc %h, required none", cyc, pc);
            end else begin
                e = sb.pop_front();
                chk("flush_cycle", cyc, e.c);
                chk("flush_pc", pc, e.a);
            end
        end
    end

    task automatic issue(input logic e, input logic [31:0] ea, input logic r0,
                         input logic [31:0] a0, input logic r1, input logic [31:0] a1);
        exc_v = e;
        exc_a = ea;
        ci[0].redirect = r0;
        ci[0].redir_addr = a0;
        ci[1].redirect = r1;
        ci[1].redir_addr = a1;
        @(negedge clk);
        exc_v = 1'b0;
        ci[0].redirect = 1'b0;
        ci[1].redirect = 1'b0;
    endtask

    initial begin
        int t;
        ci = '0;
        exc_v = 1'b0;
        exc_a = '0;
        busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_flush", {31'd0, g_flush}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // slot 1 redirect, icache idle
        t = cyc;
        sb.push_back('{t + 1, 32'h1c000100});
        issue(0, 0, 0, 0, 1, 32'h1c000100);
        chk("t1_stall_hi", {31'd0, stall}, 32'd1);
        @(negedge clk);
        chk("t1_stall_lo", {31'd0, stall}, 32'd0);

        // exception beats slot 0 in the same cycle
        t = cyc;
        sb.push_back('{t + 1, 32'h1c008000});
        issue(1, 32'h1c008000, 1, 32'h1c000040, 0, 0);
        @(negedge clk);
        chk("t2_stall_lo", {31'd0, stall}, 32'd0);

        // busy for 5 cycles then drops
        t = cyc;
        busy = 1'b1;
        sb.push_back('{t + 6, 32'h1c000500});
        issue(0, 0, 1, 32'h1c000500, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t3_stall_drain", {31'd0, stall}, 32'd1);
            @(negedge clk);
        end
        chk("t3_stall_drain", {31'd0, stall}, 32'd1);
        busy = 1'b0;
        @(negedge clk);
        chk("t3_stall_flush", {31'd0, stall}, 32'd1);
        @(negedge clk);
        chk("t3_stall_lo", {31'd0, stall}, 32'd0);

        // watchdog with busy stuck high
        t = cyc;
        busy = 1'b1;
        sb.push_back('{t + 9, 32'h1c000600});
        issue(0, 0, 0, 0, 1, 32'h1c000600);
        repeat (8) @(negedge clk);
        chk("t4_stall_flush", {31'd0, stall}, 32'd1);
        @(negedge clk);
        chk("t4_stall_lo", {31'd0, stall}, 32'd0);
        busy = 1'b0;
`ifdef F_REDIR_STAT_EN
        chk("t4_timeout", {31'd0, s_to}, 32'd1);
`endif

        // retarget during DRAIN, then a back-to-back request in the FLUSH cycle
        @(negedge clk);
        t = cyc;
        busy = 1'b1;
        sb.push_back('{t + 4, 32'h1c000200});
        issue(0, 0, 1, 32'h1c000100, 0, 0);
        @(negedge clk);
        issue(0, 0, 1, 32'h1c000200, 0, 0);
        busy = 1'b0;
        @(negedge clk);
        sb.push_back('{t + 5, 32'h1c000300});
        issue(0, 0, 0, 0, 1, 32'h1c000300);
        @(negedge clk);
        chk("t5_stall_lo", {31'd0, stall}, 32'd0);
`ifdef F_REDIR_STAT_EN
        chk("stat_flush_cnt", s_fl, 32'd6);
        chk("stat_drain_cyc", s_dr, 32'd16);
`endif

        // reset mid-DRAIN aborts the redirect
        busy = 1'b1;
        issue(0, 0, 1, 32'h1c000700, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_flush", {31'd0, g_flush}, 32'd0);
        chk("t6_rst_pc", pc, 32'd0);
        chk("t6_rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        busy = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_stall_after", {31'd0, stall}, 32'd0);

        chk("sb_leftover", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
